boss_bullet_pool: RTL and testbench
===================================

BOSS_BULLET_POOL -- requirements
Module: boss_bullet_pool

Interface
REQ-001 Parameter N_SLOTS, default 4: number of concurrent boss bullets, range 1..8.
REQ-002 Parameter FIRE_PERIOD, default 480: ticks between spawn attempts.
REQ-003 Parameter SPEED, default 1: pixels added to bullet y per tick.
REQ-004 Parameter BW, default 20; BH, default 60: bullet sprite width and height in pixels.
REQ-005 Parameter SPAWN_DX, default 54; SPAWN_DY, default 60: spawn offset from boss origin.
REQ-006 Parameter Y_OFS, default 480; Y_LIMIT, default 960: virtual-y offset of visible screen, and retire threshold.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 tick  input  1  one-cycle motion/fire strobe (frame-rate enable).
REQ-010 boss_x, boss_y  input  10 each  current boss origin.
REQ-011 boss_exist  input  1  boss alive.
REQ-012 x, y  input  10 each  current scan pixel.
REQ-013 hit_valid  input  1  one-cycle collision report; hit_idx  input  3  slot hit.
REQ-014 bb_x, bb_y  output  10*N_SLOTS each  flat slot coordinates; slot i at bits [10i+9:10i].
REQ-015 active  output  N_SLOTS  per-slot live flag.
REQ-016 pix_en  output  1  scan pixel lies inside any live bullet.
REQ-017 pix_slot  output  3  lowest-index slot covering the pixel; 0 when pix_en=0.
REQ-018 rom_addr  output  11  sprite address col + row*BW for pix_slot; 0 when pix_en=0.
REQ-019 drop_cnt  output  8  saturating count of spawns lost to a full pool.

Function
REQ-020 Fire counter SHALL increment on each tick while boss_exist=1 and wrap from FIRE_PERIOD-1 to 0.
REQ-021 On a tick with counter=FIRE_PERIOD-1 and boss_exist=1, the lowest-index inactive slot SHALL load (boss_x+SPAWN_DX, boss_y+SPAWN_DY) mod 1024 and go active.
REQ-022 If no slot is inactive at a spawn tick, the spawn SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-023 On each tick, every active slot not spawning that cycle SHALL advance bb_y by SPEED; a newly spawned slot SHALL NOT move on its spawn tick.
REQ-024 A slot whose advanced bb_y exceeds Y_LIMIT SHALL go inactive on that tick, with bb_y holding the advanced value; sums are computed at 11 bits (no wrap).
REQ-025 hit_valid with hit_idx<N_SLOTS SHALL clear active[hit_idx] next edge; hit_idx>=N_SLOTS SHALL be ignored.
REQ-026 Hit and move on the same slot in the same cycle: the hit wins (slot inactive).
REQ-027 Free-slot selection SHALL use the pre-edge active mask; a slot freed by hit or retire that cycle is reusable only on a later spawn.
REQ-028 boss_exist=0 SHALL clear all active bits and the fire counter on the next edge, regardless of tick.
REQ-029 pix_en, pix_slot and rom_addr SHALL be combinational from x, y and registered slot state: coverage is x>=bb_x, x<bb_x+BW, y+Y_OFS>=bb_y, y+Y_OFS<bb_y+BH, computed at 11 bits, active slots only.
REQ-030 rom_addr SHALL equal (x-bb_x) + (y+Y_OFS-bb_y)*BW of pix_slot, max BW*BH-1.
REQ-031 Inactive slots SHALL hold their last coordinates.

Reset
REQ-032 rst=1 SHALL immediately force active=0, fire counter=0, drop_cnt=0, all bb_x/bb_y=0; pix_en, pix_slot, rom_addr consequently 0.
REQ-033 Reset asserted mid-flight SHALL discard all bullets; first spawn after release occurs at the FIRE_PERIOD-th tick with boss_exist=1.

Verification
REQ-034 FIRE_PERIOD=4, boss (100,50), boss_exist=1, 4 ticks -> slot0 active at (154,110); next tick bb_y=111.
REQ-035 N_SLOTS=2, FIRE_PERIOD=2, no hits, 6 ticks -> slots 0,1 active, drop_cnt=1.
REQ-036 Slot0 at bb_y=960, SPEED=1, tick -> active[0]=0, bb_y=961.
REQ-037 Slot1 live, hit_valid with hit_idx=1 on a tick cycle -> active[1]=0, bb_y unchanged; same-cycle spawn goes to another free slot, not slot1.
REQ-038 Slot0 at (154,490), scan x=160,y=20 -> pix_en=1, pix_slot=0, rom_addr=6+10*20=206; x=174 -> pix_en=0.
REQ-039 Two bullets live, rst pulsed between clock edges -> active=0 without a clock edge; boss_exist low for a cycle -> all slots cleared.

Source files
------------

// File: rtl/boss_bullet_pool_if.sv
// Bundle of boss control, scan, hit and bullet-state signals shared by the
// bullet pool and whatever drives it.
interface boss_bullet_pool_if #(
  parameter int unsigned N_SLOTS = 4
);
  logic                    tick;
  logic [9:0]              boss_x;
  logic [9:0]              boss_y;
  logic                    boss_exist;
  logic [9:0]              x;
  logic [9:0]              y;
  logic                    hit_valid;
  logic [2:0]              hit_idx;
  logic [10*N_SLOTS-1:0]   bb_x;
  logic [10*N_SLOTS-1:0]   bb_y;
  logic [N_SLOTS-1:0]      active;
  logic                    pix_en;
  logic [2:0]              pix_slot;
  logic [10:0]             rom_addr;
  logic [7:0]              drop_cnt;

  modport master (
    output tick, boss_x, boss_y, boss_exist, x, y, hit_valid, hit_idx,
    input  bb_x, bb_y, active, pix_en, pix_slot, rom_addr, drop_cnt
  );

  modport slave (
    input  tick, boss_x, boss_y, boss_exist, x, y, hit_valid, hit_idx,
    output bb_x, bb_y, active, pix_en, pix_slot, rom_addr, drop_cnt
  );
endinterface

// File: rtl/boss_bullet_pool.sv
// Fixed pool of boss bullets: periodic spawn from the boss, downward motion,
// retire at the bottom limit, hit clearing, and per-pixel sprite lookup.
module boss_bullet_pool #(
  parameter int unsigned N_SLOTS     = 4,
  parameter int unsigned FIRE_PERIOD = 480,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned BW          = 20,
  parameter int unsigned BH          = 60,
  parameter int unsigned SPAWN_DX    = 54,
  parameter int unsigned SPAWN_DY    = 60,
  parameter int unsigned Y_OFS       = 480,
  parameter int unsigned Y_LIMIT     = 960
) (
  input  logic                 clk,
  input  logic                 rst,
  boss_bullet_pool_if.slave    bus_io
);

  localparam int unsigned CW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FIRE_PERIOD - 1);

  logic [CW-1:0]      fire_cnt_q, fire_cnt_d;
  logic [7:0]         drop_q, drop_d;
  logic [N_SLOTS-1:0] act_q, act_d;
  logic [9:0]         bx_q [N_SLOTS];
  logic [9:0]         bx_d [N_SLOTS];
  logic [9:0]         by_q [N_SLOTS];
  logic [9:0]         by_d [N_SLOTS];

  logic [10:0]        adv_y [N_SLOTS];
  logic [10:0]        col   [N_SLOTS];
  logic [10:0]        row   [N_SLOTS];
  logic [N_SLOTS-1:0] cov;
  logic [10:0]        yv;

  logic               spawn_tick;
  logic               free_found;
  logic [2:0]         free_idx;

  logic               pix_en_c;
  logic [2:0]         pix_slot_c;
  logic [10:0]        rom_c;

  assign yv = 11'(bus_io.y) + 11'(Y_OFS);

  // Per-slot motion sum, scan coverage and flat output packing
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    assign adv_y[g] = 11'(by_q[g]) + 11'(SPEED);
    assign col[g]   = 11'(bus_io.x) - 11'(bx_q[g]);
    assign row[g]   = yv - 11'(by_q[g]);
    assign cov[g]   = act_q[g]
                    && (bus_io.x >= bx_q[g])
                    && (11'(bus_io.x) < 11'(bx_q[g]) + 11'(BW))
                    && (yv >= 11'(by_q[g]))
                    && (yv < 11'(by_q[g]) + 11'(BH));
    assign bus_io.bb_x[10*g +: 10] = bx_q[g];
    assign bus_io.bb_y[10*g +: 10] = by_q[g];
  end

  assign bus_io.active   = act_q;
  assign bus_io.drop_cnt = drop_q;
  assign bus_io.pix_en   = pix_en_c;
  assign bus_io.pix_slot = pix_slot_c;
  assign bus_io.rom_addr = rom_c;

  // Next-state: free slot is chosen from the pre-edge mask so freed slots wait a spawn
  always_comb begin
    fire_cnt_d = fire_cnt_q;
    drop_d     = drop_q;
    act_d      = act_q;
    bx_d       = bx_q;
    by_d       = by_q;
    spawn_tick = bus_io.tick && bus_io.boss_exist && (fire_cnt_q == CNT_LAST);
    free_found = 1'b0;
    free_idx   = 3'd0;

    for (int i = 0; i < N_SLOTS; i++) begin
      if (!act_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end

    if (!bus_io.boss_exist) begin
      act_d      = '0;
      fire_cnt_d = '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (act_q[i]) begin
          if (bus_io.hit_valid && (bus_io.hit_idx == 3'(i))) begin
            act_d[i] = 1'b0;
          end else if (bus_io.tick) begin
            by_d[i] = adv_y[i][9:0];
            if (adv_y[i] > 11'(Y_LIMIT)) act_d[i] = 1'b0;
          end
        end else if (spawn_tick && free_found && (free_idx == 3'(i))) begin
          bx_d[i]  = bus_io.boss_x + 10'(SPAWN_DX);
          by_d[i]  = bus_io.boss_y + 10'(SPAWN_DY);
          act_d[i] = 1'b1;
        end
      end

      if (spawn_tick && !free_found && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

      if (bus_io.tick) fire_cnt_d = (fire_cnt_q == CNT_LAST) ? '0 : fire_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_cnt_q <= '0;
      drop_q     <= '0;
      act_q      <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else begin
      fire_cnt_q <= fire_cnt_d;
      drop_q     <= drop_d;
      act_q      <= act_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
    end
  end

  // Scan lookup: lowest-index covering slot wins
  always_comb begin
    pix_en_c   = 1'b0;
    pix_slot_c = 3'd0;
    rom_c      = 11'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (cov[i] && !pix_en_c) begin
        pix_en_c   = 1'b1;
        pix_slot_c = 3'(i);
        rom_c      = col[i] + row[i] * 11'(BW);
      end
    end
  end

endmodule

// File: tb/tb_boss_bullet_pool.sv
// Randomized bench for boss_bullet_pool with a slot-list reference model and
// directed literal checkpoints.
module tb_boss_bullet_pool;
  localparam int N  = 4;
  localparam int FP = 4;
  localparam int SP = 1;
  localparam int BWD = 20;
  localparam int BHT = 60;
  localparam int YO  = 480;
  localparam int YL  = 960;

  logic clk;
  logic rst;
  bit   chk_on;

  int n_cmp;
  int n_bad;

  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_cnt;
  int m_drop;

  boss_bullet_pool_if #(.N_SLOTS(N)) bus ();

  boss_bullet_pool #(.N_SLOTS(N), .FIRE_PERIOD(FP)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cnt  = 0;
    m_drop = 0;
  endtask

  // One clock edge of the game rules, applied to the bench's slot list
  task automatic mdl_step();
    int fr;
    bit spawn;
    if (rst) begin
      mdl_reset();
      return;
    end
    if (!bus.boss_exist) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      m_cnt = 0;
      return;
    end
    spawn = bus.tick && (m_cnt == FP - 1);
    fr = -1;
    for (int i = 0; i < N; i++) if (m_act[i] == 0 && fr < 0) fr = i;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0) begin
        if (bus.hit_valid && int'(bus.hit_idx) == i) m_act[i] = 0;
        else if (bus.tick) begin
          m_y[i] = m_y[i] + SP;
          if (m_y[i] > YL) m_act[i] = 0;
          m_y[i] = m_y[i] % 1024;
        end
      end
    end
    if (spawn) begin
      if (fr >= 0) begin
        m_x[fr]   = (int'(bus.boss_x) + 54) % 1024;
        m_y[fr]   = (int'(bus.boss_y) + 60) % 1024;
        m_act[fr] = 1;
      end else if (m_drop < 255) m_drop++;
    end
    if (bus.tick) m_cnt = (m_cnt + 1) % FP;
  endtask

  task automatic clk_step();
    @(posedge clk);
    mdl_step();
    #1;
    bus.tick      = 1'b0;
    bus.hit_valid = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      int pe, ps, ra, px, py;
      pe = 0; ps = 0; ra = 0;
      px = int'(bus.x);
      py = int'(bus.y) + YO;
      for (int i = 0; i < N; i++) begin
        chk($sformatf("active[%0d]", i), int'(bus.active[i]), m_act[i]);
        chk($sformatf("bb_x[%0d]", i), int'(bus.bb_x[10*i +: 10]), m_x[i]);
        chk($sformatf("bb_y[%0d]", i), int'(bus.bb_y[10*i +: 10]), m_y[i]);
        if (pe == 0 && m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + BWD &&
            py >= m_y[i] && py < m_y[i] + BHT) begin
          pe = 1; ps = i;
          ra = (px - m_x[i]) + (py - m_y[i]) * BWD;
        end
      end
      chk("pix_en", int'(bus.pix_en), pe);
      chk("pix_slot", int'(bus.pix_slot), ps);
      chk("rom_addr", int'(bus.rom_addr), ra);
      chk("drop_cnt", int'(bus.drop_cnt), m_drop);
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.tick = 1'b0; bus.boss_x = '0; bus.boss_y = '0; bus.boss_exist = 1'b0;
    bus.x = '0; bus.y = '0; bus.hit_valid = 1'b0; bus.hit_idx = '0;
    n_cmp = 0; n_bad = 0;
    mdl_reset();
    clk_step();
    chk_on = 1'b1;
    clk_step();
    chk("rst_active", int'(bus.active), 0);
    chk("rst_drop", int'(bus.drop_cnt), 0);
    chk("rst_pix_en", int'(bus.pix_en), 0);
    rst = 1'b0;

    // First spawn on the FIRE_PERIOD-th tick, then one pixel of motion
    bus.boss_exist = 1'b1; bus.boss_x = 10'd100; bus.boss_y = 10'd50;
    for (int k = 0; k < 4; k++) begin
      bus.tick = 1'b1; clk_step(); clk_step();
    end
    chk("spawn_active", int'(bus.active), 1);
    chk("spawn_x", int'(bus.bb_x[9:0]), 154);
    chk("spawn_y", int'(bus.bb_y[9:0]), 110);
    bus.tick = 1'b1; clk_step();
    chk("move_y", int'(bus.bb_y[9:0]), 111);

    // Ride slot 0 down to y=490 for the sprite-address checkpoint
    guard = 0;
    while (m_y[0] != 490 && guard < 1000) begin
      bus.tick = 1'b1; clk_step(); guard++;
    end
    chk("reach_y490", int'(bus.bb_y[9:0]), 490);
    chk("drop_full_pool", int'(bus.drop_cnt), 92);
    bus.x = 10'd160; bus.y = 10'd20; #1;
    chk("pix_en_in", int'(bus.pix_en), 1);
    chk("pix_slot_in", int'(bus.pix_slot), 0);
    chk("rom_addr_in", int'(bus.rom_addr), 206);
    bus.x = 10'd174; #1;
    chk("pix_en_edge", int'(bus.pix_en), 0);

    // Asynchronous reset between edges
    rst = 1'b1; mdl_reset(); #1;
    chk("async_active", int'(bus.active), 0);
    chk("async_bbx", int'(bus.bb_x[9:0]), 0);
    chk("async_drop", int'(bus.drop_cnt), 0);
    clk_step();
    rst = 1'b0;

    // boss_exist low clears every slot but keeps coordinates
    bus.boss_x = 10'd0; bus.boss_y = 10'd0;
    for (int k = 0; k < 8; k++) begin
      bus.tick = 1'b1; clk_step();
    end
    chk("two_live", int'(bus.active), 3);
    bus.boss_exist = 1'b0; clk_step();
    chk("exist_clear", int'(bus.active), 0);
    chk("exist_hold_y", int'(bus.bb_y[9:0]), 64);
    bus.boss_exist = 1'b1;

    // Hit on slot 1 during a spawn tick: spawn lands in slot 2
    for (int k = 0; k < 11; k++) begin
      bus.tick = 1'b1; clk_step();
    end
    bus.tick = 1'b1; bus.hit_valid = 1'b1; bus.hit_idx = 3'd1; clk_step();
    chk("hit_mask", int'(bus.active), 5);
    chk("hit_hold_y1", int'(bus.bb_y[19:10]), 63);
    chk("hit_spawn_y2", int'(bus.bb_y[29:20]), 60);
    chk("hit_move_y0", int'(bus.bb_y[9:0]), 68);

    // Retire at the bottom limit, then a spawn whose y wraps mod 1024
    rst = 1'b1; mdl_reset(); clk_step(); rst = 1'b0;
    bus.boss_y = 10'd900;
    for (int k = 0; k < 4; k++) begin
      bus.tick = 1'b1; clk_step();
    end
    chk("at_limit_y", int'(bus.bb_y[9:0]), 960);
    chk("at_limit_act", int'(bus.active[0]), 1);
    bus.tick = 1'b1; clk_step();
    chk("retire_act", int'(bus.active[0]), 0);
    chk("retire_y", int'(bus.bb_y[9:0]), 961);
    bus.boss_y = 10'd1000;
    for (int k = 0; k < 3; k++) begin
      bus.tick = 1'b1; clk_step();
    end
    chk("wrap_spawn_y", int'(bus.bb_y[9:0]), 36);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int s, idx, tx, ty;
      bus.tick       = ($urandom_range(0, 3) != 0);
      bus.boss_exist = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.boss_x = 10'($urandom);
        bus.boss_y = 10'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, 7));
        if (idx >= N || m_act[idx] != 0) begin
          bus.hit_valid = 1'b1;
          bus.hit_idx   = 3'(idx);
        end
      end
      s  = int'($urandom_range(0, N - 1));
      tx = m_x[s] + int'($urandom_range(0, 27)) - 4;
      ty = m_y[s] - YO + int'($urandom_range(0, 67)) - 4;
      bus.x = 10'(tx);
      bus.y = 10'(ty);
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        mdl_reset();
      end
      clk_step();
      rst = 1'b0;
    end

    clk_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
